// File: rtl/freq_meter.sv
// Gated frequency / period meter: counts rising edges of an asynchronous signal
// over a fixed window of clk cycles and times the spacing between consecutive edges.
module freq_meter #(
    parameter int GATE_CYCLES = 50000000,
    parameter int CNT_W       = 26,
    parameter int PER_W       = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] edge_count,
    output logic             valid,
    output logic             overflow,
    output logic [PER_W-1:0] period,
    output logic             period_valid
);
    localparam int               TMR_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [PER_W-1:0] PER_MAX  = '1;

    typedef enum logic {IDLE, GATE} state_t;

    state_t           state;
    state_t           state_next;
    logic             counting;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] acc;
    logic             win_ovf;
    logic [PER_W-1:0] per_cnt;
    logic             have_prev;
    logic             acc_full;
    logic             window_end;

    // s1/s2 resynchronise sig_in; s3 keeps the previous sample for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise       = s2 & ~s3;
    assign acc_full   = (acc == CNT_MAX);
    assign window_end = (timer == TMR_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        counting   = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_next = GATE;
                end
            end
            GATE: begin
                if (en) begin
                    counting = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A cycle with en low in GATE is already leaving, so it discards like IDLE does
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer        <= '0;
            acc          <= '0;
            win_ovf      <= 1'b0;
            per_cnt      <= '0;
            have_prev    <= 1'b0;
            edge_count   <= '0;
            overflow     <= 1'b0;
            period       <= '0;
            valid        <= 1'b0;
            period_valid <= 1'b0;
        end else begin
            valid        <= 1'b0;
            period_valid <= 1'b0;
            if (counting) begin
                if (window_end) begin
                    timer      <= '0;
                    edge_count <= (rise && !acc_full) ? acc + 1'b1 : acc;
                    overflow   <= win_ovf | (rise & acc_full);
                    valid      <= 1'b1;
                    acc        <= '0;
                    win_ovf    <= 1'b0;
                end else begin
                    timer <= timer + 1'b1;
                    if (rise) begin
                        if (acc_full) begin
                            win_ovf <= 1'b1;
                        end else begin
                            acc <= acc + 1'b1;
                        end
                    end
                end

                // per_cnt restarts at 1 so the next rise reports the full edge-to-edge distance
                if (rise) begin
                    if (have_prev) begin
                        period       <= per_cnt;
                        period_valid <= 1'b1;
                    end
                    per_cnt   <= PER_W'(1);
                    have_prev <= 1'b1;
                end else if (per_cnt != PER_MAX) begin
                    per_cnt <= per_cnt + 1'b1;
                end
            end else begin
                timer     <= '0;
                acc       <= '0;
                win_ovf   <= 1'b0;
                per_cnt   <= '0;
                have_prev <= 1'b0;
            end
        end
    end

endmodule
